// File: rtl/tmax_pkg.sv
// Shared definitions for the channel-maximum readout: FSM states, result-word
// field positions and default sizing.
package tmax_pkg;

    localparam int DEFAULT_WIDTH = 19;
    localparam int NUM_W         = 5;
    localparam int MAX_W         = 10;
    localparam int DOUT_W        = 16;

    localparam int DOUT_NUM_MSB  = 15;
    localparam int DOUT_NUM_LSB  = 11;
    localparam int DOUT_RSV_BIT  = 10;
    localparam int DOUT_MAX_MSB  = 9;
    localparam int DOUT_MAX_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SEND   = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/tmax_readout.sv
// Sequential readout of per-channel maxima from a tracker into a handshaked word stream.
// Optional clear-after-read of each channel is enabled by defining TMAX_READOUT_CLEAR_EN.
module tmax_readout
    import tmax_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    output logic [NUM_W-1:0]  NUMBER,
    input  logic [MAX_W-1:0]  TOUT,
    output logic [WIDTH:0]    EN_CPU,
    output logic              TRESET,
    output logic [DOUT_W-1:0] DOUT,
    output logic              DVALID,
    input  logic              DREADY,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [NUM_W-1:0] LAST_CH  = NUM_W'(WIDTH + 1);
    localparam logic [NUM_W-1:0] FIRST_CH = NUM_W'(1);
    localparam logic [WIDTH:0]   CH_BIT0  = (WIDTH+1)'(1);

    state_t              state;
    state_t              state_nxt;
    logic                load;
    logic                advance;
    logic                last_ch;
    logic [DOUT_W-1:0]   word;

    assign last_ch = (NUMBER >= LAST_CH);

    always_comb begin
        word = '0;
        word[DOUT_NUM_MSB:DOUT_NUM_LSB] = NUMBER;
        word[DOUT_RSV_BIT]              = 1'b0;
        word[DOUT_MAX_MSB:DOUT_MAX_LSB] = TOUT;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                load      = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (DREADY) begin
`ifdef TMAX_READOUT_CLEAR_EN
                    state_nxt = ST_CLEAR;
`else
                    advance   = 1'b1;
                    state_nxt = last_ch ? ST_FINISH : ST_SELECT;
`endif
                end
            end
`ifdef TMAX_READOUT_CLEAR_EN
            ST_CLEAR: begin
                advance   = 1'b1;
                state_nxt = last_ch ? ST_FINISH : ST_SELECT;
            end
`endif
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // TOUT is captured only on the SELECT->SEND edge so later tracker updates cannot disturb a pending word
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            NUMBER <= '0;
            DOUT   <= '0;
            DVALID <= 1'b0;
        end else begin
            if (state == ST_IDLE && START) begin
                NUMBER <= FIRST_CH;
            end else if (advance) begin
                NUMBER <= last_ch ? '0 : NUMBER + FIRST_CH;
            end

            if (load) begin
                DOUT   <= word;
                DVALID <= 1'b1;
            end else if (state == ST_SEND && DREADY) begin
                DVALID <= 1'b0;
            end
        end
    end

    assign BUSY = (state != ST_IDLE);
    assign DONE = (state == ST_FINISH);

`ifdef TMAX_READOUT_CLEAR_EN
    assign TRESET = (state == ST_CLEAR);
    assign EN_CPU = TRESET ? (CH_BIT0 << (NUMBER - FIRST_CH)) : '0;
`else
    assign TRESET = 1'b0;
    assign EN_CPU = '0;
`endif

endmodule
